// File: rtl/mealy_ctrl_pkg.sv
// Shared state encoding and default sizing for the Mealy stream controller.
package mealy_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLR    = 2'd1,
      SHIFT  = 2'd2,
      REPORT = 2'd3
   } state_e;

   localparam int DEF_WORD_W = 16;
   localparam int DEF_CNT_W  = 5;
   localparam int DEF_TOT_W  = 16;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shifter, MSB first, with a bit counter that flags the final bit.
module piso_shift #(
   parameter int WORD_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [WORD_W-1:0] data_i,
   input  logic              cnt_clr_i,
   input  logic              shift_en_i,
   output logic              q_msb_o,
   output logic              last_bit_o
);

   localparam int BC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   logic [WORD_W-1:0] shreg_q;
   logic [BC_W-1:0]   bit_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         if (load_i) begin
            shreg_q <= data_i;
         end else if (shift_en_i) begin
            shreg_q <= {shreg_q[WORD_W-2:0], 1'b0};
         end
         if (cnt_clr_i) begin
            bit_cnt_q <= '0;
         end else if (shift_en_i) begin
            bit_cnt_q <= bit_cnt_q + BC_W'(1);
         end
      end
   end

   assign q_msb_o    = shreg_q[WORD_W-1];
   assign last_bit_o = (bit_cnt_q == BC_W'(WORD_W - 1));

endmodule

// File: rtl/mealy_stream_ctrl.sv
// Feeds words bit-serially into a 1-bit Mealy detector, clearing it before each word,
// and reports per-word hit counts plus a running total over a held result handshake.
module mealy_stream_ctrl
   import mealy_ctrl_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W,
   parameter int CNT_W  = DEF_CNT_W,
   parameter int TOT_W  = DEF_TOT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_word,
   input  logic              abort,
   output logic              det_clr,
   output logic              det_in,
   input  logic              det_hit,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CNT_W-1:0]  res_hits,
   output logic              res_abort,
   output logic [TOT_W-1:0]  tot_hits
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   state_e             state_q, state_d;
   logic               in_ready_q;
   logic               det_clr_q;
   logic               res_valid_q;
   logic               res_abort_q;
   logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]   res_hits_q;
   logic [TOT_W-1:0]   tot_hits_q;

   logic               accept;
   logic               in_shift;
   logic               enter_report;
   logic               q_msb;
   logic               last_bit;

   assign accept       = in_valid & in_ready_q;
   assign in_shift     = (state_q == SHIFT);
   assign enter_report = (state_d == REPORT) && (state_q != REPORT);

   piso_shift #(
      .WORD_W (WORD_W)
   ) u_piso (
      .clk_i      (clk),
      .rst_ni     (rst),
      .load_i     (accept),
      .data_i     (in_word),
      .cnt_clr_i  (state_q == CLR),
      .shift_en_i (in_shift),
      .q_msb_o    (q_msb),
      .last_bit_o (last_bit)
   );

   // The hit seen on the final (or aborting) shift cycle is folded into hit_cnt_d,
   // so the result registers below capture it on REPORT entry.
   always_comb begin
      state_d   = state_q;
      hit_cnt_d = hit_cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = CLR;
               hit_cnt_d = '0;
            end
         end
         CLR: begin
            state_d = abort ? REPORT : SHIFT;
         end
         SHIFT: begin
            if (det_hit) begin
               hit_cnt_d = sat_inc(hit_cnt_q);
            end
            if (abort || last_bit) begin
               state_d = REPORT;
            end
         end
         REPORT: begin
            if (res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b0;
         det_clr_q   <= 1'b1;
         res_valid_q <= 1'b0;
         res_abort_q <= 1'b0;
         hit_cnt_q   <= '0;
         res_hits_q  <= '0;
         tot_hits_q  <= '0;
      end else begin
         state_q     <= state_d;
         hit_cnt_q   <= hit_cnt_d;
         in_ready_q  <= (state_d == IDLE);
         det_clr_q   <= (state_d == CLR);
         res_valid_q <= (state_d == REPORT);
         if (enter_report) begin
            res_hits_q  <= hit_cnt_d;
            res_abort_q <= abort;
            if (!abort) begin
               tot_hits_q <= tot_hits_q + TOT_W'(hit_cnt_d);
            end
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign det_clr   = det_clr_q;
   assign det_in    = in_shift & q_msb;
   assign res_valid = res_valid_q;
   assign res_hits  = res_hits_q;
   assign res_abort = res_abort_q;
   assign tot_hits  = tot_hits_q;

endmodule

// File: tb/tb_mealy_stream_ctrl.sv
// Directed bench for mealy_stream_ctrl paired with a behavioural 1011 overlapping Mealy detector.
module tb_mealy_stream_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_word;
   logic        abort;
   logic        det_clr;
   logic        det_in;
   logic        det_hit;
   logic        res_valid;
   logic        res_ready;
   logic [4:0]  res_hits;
   logic        res_abort;
   logic [15:0] tot_hits;

   int total = 0;
   int bad   = 0;
   int exp_tot = 0;

   always #5 clk = ~clk;

   mealy_stream_ctrl #(.WORD_W(16), .CNT_W(5), .TOT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_word   (in_word),
      .abort     (abort),
      .det_clr   (det_clr),
      .det_in    (det_in),
      .det_hit   (det_hit),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_hits  (res_hits),
      .res_abort (res_abort),
      .tot_hits  (tot_hits)
   );

   // Detector: Mealy, overlapping, sequence 1011, synchronous active-high clear.
   localparam logic [3:0] SEQ = 4'b1011;
   logic [2:0] hist_q;
   always_ff @(posedge clk) begin
      if (det_clr) hist_q <= '0;
      else         hist_q <= {hist_q[1:0], det_in};
   end
   assign det_hit = ({hist_q, det_in} == SEQ);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd0);
      chk({tag, "_det_clr"},   32'(det_clr),   32'd1);
      chk({tag, "_det_in"},    32'(det_in),    32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
      chk({tag, "_res_hits"},  32'(res_hits),  32'd0);
      chk({tag, "_res_abort"}, 32'(res_abort), 32'd0);
      chk({tag, "_tot_hits"},  32'(tot_hits),  32'd0);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
   endtask

   // Offers one word, optionally aborts (-2 = in CLR, k>=0 = at shift bit k),
   // and returns at the negedge of the first REPORT cycle.
   task automatic run_word(input logic [15:0] w, input int abort_at, input int exp_hits,
                           input bit exp_abort, input string tag);
      int          n_shift;
      logic [15:0] stream;
      logic [15:0] mask;
      bit          early;
      wait_ready(tag);
      in_valid = 1'b1;
      in_word  = w;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_clr_cycle"}, 32'({det_clr, det_in, in_ready}), 32'b100);
      abort   = (abort_at == -2);
      n_shift = (abort_at == -2) ? 0 : (abort_at >= 0) ? abort_at + 1 : 16;
      stream  = '0;
      early   = 1'b0;
      for (int b = 0; b < n_shift; b++) begin
         @(negedge clk);
         stream[15-b] = det_in;
         if (res_valid !== 1'b0 || det_clr !== 1'b0) early = 1'b1;
         abort = (b == abort_at);
      end
      @(negedge clk);
      abort = 1'b0;
      if (n_shift > 0) begin
         mask = ~(16'hFFFF >> n_shift);
         chk({tag, "_det_in_stream"}, 32'(stream), 32'(w & mask));
      end
      if (!exp_abort) exp_tot += exp_hits;
      chk({tag, "_no_early_valid"}, 32'(early), 32'd0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_res_hits"},  32'(res_hits),  32'(exp_hits));
      chk({tag, "_res_abort"}, 32'(res_abort), 32'(exp_abort));
      chk({tag, "_tot_hits"},  32'(tot_hits),  32'(exp_tot[15:0]));
      chk({tag, "_busy"},      32'(in_ready),  32'd0);
   endtask

   typedef struct {
      logic [15:0] word;
      int          abort_at;
      int          exp_hits;
      bit          exp_abort;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      int   cyc, clr_cnt, second;
      bit   done, stable;

      vecs[0]  = '{16'hD69A, -1, 1, 1'b0};
      vecs[1]  = '{16'h0000, -1, 0, 1'b0};
      vecs[2]  = '{16'hFFFF, -1, 0, 1'b0};
      vecs[3]  = '{16'hB000, -1, 1, 1'b0};
      vecs[4]  = '{16'hBBBB, -1, 4, 1'b0};
      vecs[5]  = '{16'hB6DB, -1, 5, 1'b0};
      vecs[6]  = '{16'h000B, -1, 1, 1'b0};
      vecs[7]  = '{16'hB6DB,  7, 2, 1'b1};
      vecs[8]  = '{16'hBBBB, -2, 0, 1'b1};
      vecs[9]  = '{16'h000B, 15, 1, 1'b1};
      vecs[10] = '{16'h000B, 14, 0, 1'b1};

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_word   = '0;
      abort     = 1'b0;
      res_ready = 1'b1;

      // Reset held, then released between edges
      #25;
      chk_reset_vals("rst_hold");
      #27;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rel_in_ready", 32'(in_ready), 32'd1);
      chk("rst_rel_det_clr",  32'(det_clr),  32'd0);

      // Table of words, res_ready tied high
      for (int i = 0; i < 11; i++) begin
         run_word(vecs[i].word, vecs[i].abort_at, vecs[i].exp_hits, vecs[i].exp_abort,
                  $sformatf("vec%0d", i));
         @(negedge clk);
         chk($sformatf("vec%0d_idle", i), 32'({in_ready, res_valid}), 32'b10);
      end

      // Back-to-back words with in_valid held
      wait_ready("b2b");
      in_valid = 1'b1;
      in_word  = 16'h0000;
      cyc = 0; clr_cnt = 0; second = -1; done = 1'b0;
      while (!done && cyc < 80) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) in_word = 16'hFFFF;
         if (det_clr === 1'b1) clr_cnt++;
         if (second < 0 && cyc > 1 && in_ready === 1'b1) second = cyc;
         else if (second >= 0 && cyc == second + 1) in_valid = 1'b0;
         if (second >= 0 && cyc > second && res_valid === 1'b1) done = 1'b1;
      end
      chk("b2b_done",         32'(done),     32'd1);
      chk("b2b_second_accept", 32'(second),  32'd19);
      chk("b2b_clr_pulses",   32'(clr_cnt),  32'd2);
      chk("b2b_res_hits",     32'(res_hits), 32'd0);
      chk("b2b_tot_hits",     32'(tot_hits), 32'(exp_tot[15:0]));
      @(negedge clk);
      chk("b2b_idle", 32'({in_ready, res_valid}), 32'b10);

      // Result held with res_ready low while another word is offered
      res_ready = 1'b0;
      run_word(16'hB6DB, -1, 5, 1'b0, "hold");
      in_valid = 1'b1;
      in_word  = 16'hBBBB;
      stable   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!(res_valid === 1'b1 && res_hits === 5'd5 && res_abort === 1'b0 &&
               in_ready === 1'b0 && det_clr === 1'b0)) stable = 1'b0;
      end
      chk("hold_stable", 32'(stable), 32'd1);
      res_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      chk("hold_release_idle", 32'({in_ready, res_valid}), 32'b10);
      run_word(16'hBBBB, -1, 4, 1'b0, "after_hold");
      @(negedge clk);

      // Asynchronous reset during shift bit 5
      wait_ready("mid_rst");
      in_valid = 1'b1;
      in_word  = 16'hBBBB;
      @(negedge clk);
      in_valid = 1'b0;
      for (int b = 0; b <= 5; b++) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_reset_vals("mid_rst");
      @(negedge clk);
      rst = 1'b1;
      exp_tot = 0;
      @(negedge clk);
      chk("mid_rst_ready", 32'(in_ready), 32'd1);
      run_word(16'hB6DB, -1, 5, 1'b0, "post_rst");
      @(negedge clk);
      chk("post_rst_idle", 32'({in_ready, res_valid}), 32'b10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
